// File: rtl/mu0_control_if.sv
// Control/status bundle between the MU0 sequencer and its datapath + memory.
// The controller is the master; the datapath/memory side is the slave.
interface mu0_control_if;
  logic [3:0]  f;
  logic        n;
  logic        z;
  logic        mem_ready;
  logic        x_sel;
  logic        y_sel;
  logic        addr_sel;
  logic        pc_en;
  logic        ir_en;
  logic        acc_en;
  logic [1:0]  m;
  logic        rd;
  logic        wr;
  logic        halted;
  logic [15:0] icount;

  modport master (
    input  f, n, z, mem_ready,
    output x_sel, y_sel, addr_sel, pc_en, ir_en, acc_en, m, rd, wr, halted, icount
  );

  modport slave (
    output f, n, z, mem_ready,
    input  x_sel, y_sel, addr_sel, pc_en, ir_en, acc_en, m, rd, wr, halted, icount
  );
endinterface

// File: rtl/mu0_control.sv
// MU0 instruction sequencer: FETCH/EXEC/HALT FSM with memory wait states
// and a wrapping count of completed instructions.
module mu0_control (
  input  logic           clk,
  input  logic           reset,
  mu0_control_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] icount_reg, icount_next;

  logic       x_sel, y_sel, addr_sel;
  logic       pc_en, ir_en, acc_en;
  logic [1:0] m;
  logic       rd, wr, halted;
  logic       exec_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= FETCH;
      icount_reg <= 16'h0000;
    end else begin
      state_reg  <= state_next;
      icount_reg <= icount_next;
    end
  end

  always_comb begin
    x_sel       = 1'b0;
    y_sel       = 1'b0;
    addr_sel    = 1'b0;
    pc_en       = 1'b0;
    ir_en       = 1'b0;
    acc_en      = 1'b0;
    m           = 2'b00;
    rd          = 1'b0;
    wr          = 1'b0;
    halted      = 1'b0;
    exec_done   = 1'b0;
    state_next  = state_reg;
    icount_next = icount_reg;

    case (state_reg)
      FETCH: begin
        rd    = 1'b1;
        x_sel = 1'b1;
        m     = 2'b10;
        ir_en = bus.mem_ready;
        pc_en = bus.mem_ready;
        if (bus.mem_ready) state_next = EXEC;
      end

      EXEC: begin
        // Memory ops hold address/strobe/selects across waits; only the enable tracks mem_ready.
        case (bus.f)
          4'h0: begin
            addr_sel  = 1'b1;
            rd        = 1'b1;
            acc_en    = bus.mem_ready;
            exec_done = bus.mem_ready;
          end
          4'h1: begin
            addr_sel  = 1'b1;
            wr        = 1'b1;
            exec_done = bus.mem_ready;
          end
          4'h2, 4'h3: begin
            addr_sel  = 1'b1;
            rd        = 1'b1;
            m         = (bus.f == 4'h2) ? 2'b01 : 2'b11;
            acc_en    = bus.mem_ready;
            exec_done = bus.mem_ready;
          end
          4'h4, 4'h5, 4'h6: begin
            y_sel     = 1'b1;
            pc_en     = (bus.f == 4'h4) ? 1'b1 :
                        (bus.f == 4'h5) ? ~bus.n : ~bus.z;
            exec_done = 1'b1;
          end
          default: exec_done = 1'b1;
        endcase

        if (exec_done) begin
          icount_next = icount_reg + 16'd1;
          state_next  = (bus.f == 4'h7) ? HALT : FETCH;
        end
      end

      HALT: halted = 1'b1;

      default: state_next = FETCH;
    endcase

    // Reset quiesces every strobe and enable before the register has been cleared.
    if (reset) begin
      x_sel    = 1'b0;
      y_sel    = 1'b0;
      addr_sel = 1'b0;
      pc_en    = 1'b0;
      ir_en    = 1'b0;
      acc_en   = 1'b0;
      m        = 2'b00;
      rd       = 1'b0;
      wr       = 1'b0;
      halted   = 1'b0;
    end
  end

  assign bus.x_sel    = x_sel;
  assign bus.y_sel    = y_sel;
  assign bus.addr_sel = addr_sel;
  assign bus.pc_en    = pc_en;
  assign bus.ir_en    = ir_en;
  assign bus.acc_en   = acc_en;
  assign bus.m        = m;
  assign bus.rd       = rd;
  assign bus.wr       = wr;
  assign bus.halted   = halted;
  assign bus.icount   = icount_reg;

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control: stimulus pushes hand-computed expected output
// vectors into a queue, a negedge monitor pops and compares them.
module tb_mu0_control;

  logic clk;
  logic reset;

  mu0_control_if bus_if ();

  mu0_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {x_sel, y_sel, addr_sel, pc_en, ir_en, acc_en, m[1:0], rd, wr, halted, icount[15:0]}
  logic [26:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] ic;

  function automatic logic [26:0] e(input logic x, input logic y, input logic a,
                                     input logic pc, input logic ir, input logic acc,
                                     input logic [1:0] mm, input logic r, input logic w,
                                     input logic h, input logic [15:0] cnt);
    return {x, y, a, pc, ir, acc, mm, r, w, h, cnt};
  endfunction

  function automatic logic [26:0] fetch_exp(input logic mr, input logic [15:0] cnt);
    return e(1'b1, 1'b0, 1'b0, mr, mr, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, cnt);
  endfunction

  task automatic step(input logic rst_i, input logic [3:0] f_i, input logic n_i,
                      input logic z_i, input logic mr_i, input logic [26:0] exp_v,
                      input string nm);
    reset            = rst_i;
    bus_if.f         = f_i;
    bus_if.n         = n_i;
    bus_if.z         = z_i;
    bus_if.mem_ready = mr_i;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the bench has a prediction for, compare the whole output vector.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [26:0] got, want;
      string       nm;
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = {bus_if.x_sel, bus_if.y_sel, bus_if.addr_sel, bus_if.pc_en, bus_if.ir_en,
              bus_if.acc_en, bus_if.m, bus_if.rd, bus_if.wr, bus_if.halted, bus_if.icount};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %07h required %07h", nm, got, want);
      end
      n_checks++;
      if (bus_if.rd === 1'b1 && bus_if.wr === 1'b1) begin
        n_fail++;
        $display("FAIL %s rd_wr_exclusive: got rd=1 wr=1 required not both", nm);
      end
    end
  end

  initial begin
    reset            = 1'b1;
    bus_if.f         = 4'h0;
    bus_if.n         = 1'b0;
    bus_if.z         = 1'b0;
    bus_if.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ic = 16'h0000;

    step(1, 4'h0, 0, 0, 1, e(0,0,0,0,0,0,2'b00,0,0,0,16'h0000), "reset_idle");

    // LDA with immediate memory response
    step(0, 4'h0, 0, 0, 1, fetch_exp(1, ic), "lda_fetch");
    step(0, 4'h0, 0, 0, 1, e(0,0,1,0,0,1,2'b00,1,0,0,ic), "lda_exec");
    ic = ic + 16'd1;

    // STO with three wait cycles
    step(0, 4'h1, 0, 0, 0, fetch_exp(0, ic), "fetch_wait_icount1");
    step(0, 4'h1, 0, 0, 1, fetch_exp(1, ic), "sto_fetch");
    for (int i = 0; i < 3; i++)
      step(0, 4'h1, 0, 0, 0, e(0,0,1,0,0,0,2'b00,0,1,0,ic), "sto_wait");
    step(0, 4'h1, 0, 0, 1, e(0,0,1,0,0,0,2'b00,0,1,0,ic), "sto_done");
    ic = ic + 16'd1;

    // ADD with one wait, SUB without
    step(0, 4'h2, 0, 0, 1, fetch_exp(1, ic), "add_fetch");
    step(0, 4'h2, 0, 0, 0, e(0,0,1,0,0,0,2'b01,1,0,0,ic), "add_wait");
    step(0, 4'h2, 0, 0, 1, e(0,0,1,0,0,1,2'b01,1,0,0,ic), "add_done");
    ic = ic + 16'd1;
    step(0, 4'h3, 0, 0, 1, fetch_exp(1, ic), "sub_fetch");
    step(0, 4'h3, 0, 0, 1, e(0,0,1,0,0,1,2'b11,1,0,0,ic), "sub_exec");
    ic = ic + 16'd1;

    // Jumps complete in one cycle regardless of mem_ready
    step(0, 4'h4, 1, 1, 1, fetch_exp(1, ic), "jmp_fetch");
    step(0, 4'h4, 1, 1, 0, e(0,1,0,1,0,0,2'b00,0,0,0,ic), "jmp_exec");
    ic = ic + 16'd1;
    step(0, 4'h5, 1, 0, 1, fetch_exp(1, ic), "jge_n1_fetch");
    step(0, 4'h5, 1, 0, 0, e(0,1,0,0,0,0,2'b00,0,0,0,ic), "jge_n1_exec");
    ic = ic + 16'd1;
    step(0, 4'h5, 0, 1, 1, fetch_exp(1, ic), "jge_n0_fetch");
    step(0, 4'h5, 0, 1, 0, e(0,1,0,1,0,0,2'b00,0,0,0,ic), "jge_n0_exec");
    ic = ic + 16'd1;
    step(0, 4'h6, 0, 1, 1, fetch_exp(1, ic), "jne_z1_fetch");
    step(0, 4'h6, 0, 1, 0, e(0,1,0,0,0,0,2'b00,0,0,0,ic), "jne_z1_exec");
    ic = ic + 16'd1;
    step(0, 4'h6, 1, 0, 1, fetch_exp(1, ic), "jne_z0_fetch");
    step(0, 4'h6, 1, 0, 1, e(0,1,0,1,0,0,2'b00,0,0,0,ic), "jne_z0_exec");
    ic = ic + 16'd1;

    // NOP opcode 9 leaves EXEC immediately
    step(0, 4'h9, 0, 0, 1, fetch_exp(1, ic), "nop_fetch");
    step(0, 4'h9, 0, 0, 0, e(0,0,0,0,0,0,2'b00,0,0,0,ic), "nop_exec");
    ic = ic + 16'd1;

    // STP, then HALT ignores every input
    step(0, 4'h7, 0, 0, 1, fetch_exp(1, ic), "stp_fetch");
    step(0, 4'h7, 0, 0, 1, e(0,0,0,0,0,0,2'b00,0,0,0,ic), "stp_exec");
    ic = ic + 16'd1;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] fr;
      logic       b;
      fr = 4'($urandom_range(0, 15));
      b  = i[0];
      step(0, fr, b, ~b, b, e(0,0,0,0,0,0,2'b00,0,0,1,ic), "halt_idle");
    end
    step(1, 4'h0, 0, 0, 1, e(0,0,0,0,0,0,2'b00,0,0,0,ic), "reset_from_halt");
    ic = 16'h0000;
    step(0, 4'h0, 0, 0, 0, fetch_exp(0, ic), "fetch_after_halt_reset");

    // A run of NOPs to walk the counter
    for (int i = 0; i < 40; i++) begin
      step(0, 4'h8, 0, 0, 1, fetch_exp(1, ic), "nop_run_fetch");
      step(0, 4'h8, 0, 0, 1, e(0,0,0,0,0,0,2'b00,0,0,0,ic), "nop_run_exec");
      ic = ic + 16'd1;
    end

    // Preload the counter near wrap while the FSM is parked in a FETCH wait
    step(0, 4'h8, 0, 0, 0, fetch_exp(0, ic), "preload_wait");
    dut.icount_reg = 16'hFFFE;
    ic = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      step(0, 4'h8, 0, 0, 1, fetch_exp(1, ic), "wrap_fetch");
      step(0, 4'h8, 0, 0, 1, e(0,0,0,0,0,0,2'b00,0,0,0,ic), "wrap_exec");
      ic = ic + 16'd1;
    end
    step(0, 4'h8, 0, 0, 0, fetch_exp(0, ic), "icount_wrapped_0000");
    step(0, 4'h8, 0, 0, 1, fetch_exp(1, ic), "post_wrap_fetch");
    step(0, 4'h8, 0, 0, 1, e(0,0,0,0,0,0,2'b00,0,0,0,ic), "post_wrap_exec");
    ic = ic + 16'd1;

    // Reset in the middle of a FETCH memory wait
    step(0, 4'h8, 0, 0, 0, fetch_exp(0, ic), "fetch_wait_before_reset");
    step(1, 4'h8, 0, 0, 0, e(0,0,0,0,0,0,2'b00,0,0,0,ic), "reset_mid_fetch");
    ic = 16'h0000;
    step(0, 4'h8, 0, 0, 0, fetch_exp(0, ic), "fetch_after_mid_reset");

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mu0_control.md
MU0_CONTROL -- requirements
Module: mu0_control

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 F  input  4  opcode (IR[15:12]) from datapath.
REQ-004 N  input  1  Acc negative flag.
REQ-005 Z  input  1  Acc zero flag.
REQ-006 Mem_ready  input  1  memory completes the current Rd/Wr this cycle.
REQ-007 X_sel  output  1  0=Acc, 1=PC onto ALU X / Data_out.
REQ-008 Y_sel  output  1  0=Data_in, 1=IR onto ALU Y.
REQ-009 Addr_sel  output  1  0=PC, 1=IR[11:0] onto Address.
REQ-010 PC_En, IR_En, Acc_En  output  1 each  register load enables.
REQ-011 M  output  2  ALU op: 00=Y, 01=X+Y, 10=X+1, 11=X-Y.
REQ-012 Rd, Wr  output  1 each  memory read / write strobe.
REQ-013 Halted  output  1  high while in HALT.
REQ-014 Icount  output  16  count of completed instructions.

Function
REQ-015 FSM states SHALL be FETCH, EXEC, HALT; one-hot or binary is implementer's choice.
REQ-016 Outputs not listed for a state/opcode SHALL be 0 (M=00, selects 0, enables/strobes 0).
REQ-017 FETCH: Addr_sel=0, Rd=1, X_sel=1, M=10; IR_En=PC_En=Mem_ready; Mem_ready=1 -> EXEC, else stay FETCH.
REQ-018 EXEC LDA (0): Addr_sel=1, Rd=1, Y_sel=0, M=00, Acc_En=Mem_ready.
REQ-019 EXEC STO (1): Addr_sel=1, Wr=1, X_sel=0.
REQ-020 EXEC ADD (2): Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, M=01, Acc_En=Mem_ready.
REQ-021 EXEC SUB (3): as ADD with M=11.
REQ-022 EXEC JMP (4): Y_sel=1, M=00, PC_En=1; no Rd/Wr.
REQ-023 EXEC JGE (5): as JMP with PC_En=~N.
REQ-024 EXEC JNE (6): as JMP with PC_En=~Z.
REQ-025 EXEC STP (7): no enables, no strobes; next state HALT.
REQ-026 EXEC opcodes 8-F: NOP, no enables/strobes, complete in one cycle -> FETCH.
REQ-027 Memory-accessing EXEC (0-3): Mem_ready=1 -> FETCH; Mem_ready=0 -> stay EXEC with Rd/Wr, Addr_sel, selects held stable and enables 0.
REQ-028 Non-memory EXEC (4-F) SHALL ignore Mem_ready and leave EXEC after exactly one cycle.
REQ-029 Minimum latency: 2 cycles per instruction (FETCH+EXEC), plus one cycle per Mem_ready=0 wait cycle.
REQ-030 Rd and Wr SHALL never be asserted in the same cycle.
REQ-031 HALT: all enables/strobes 0, Halted=1; remains until Reset regardless of other inputs.
REQ-032 Icount SHALL increment by 1 on the cycle EXEC completes (including STP and NOP), wrapping FFFF->0000.
REQ-033 Outputs are a function of state, F, N, Z, Mem_ready only; F SHALL be sampled combinationally from IR during EXEC.

Reset
REQ-034 Reset=1 at a rising edge SHALL force state=FETCH and Icount=0000, overriding any in-progress wait or HALT.
REQ-035 While Reset=1, PC_En, IR_En, Acc_En, Rd, Wr SHALL be 0 and Halted SHALL be 0.
REQ-036 First cycle after Reset deasserts SHALL be FETCH with Rd=1, Addr_sel=0.

Verification
REQ-037 Reset, Mem_ready=1, F=0 -> FETCH cycle IR_En=PC_En=1, M=10; next cycle Rd=1, Addr_sel=1, Acc_En=1, M=00; Icount=0001.
REQ-038 F=1 (STO), Mem_ready low 3 cycles then high -> Wr=1, Addr_sel=1, X_sel=0 held 4 cycles, Rd=0 throughout; FETCH follows.
REQ-039 F=5 with N=1 then F=5 with N=0 -> PC_En=0 then PC_En=1, Y_sel=1, M=00; each EXEC one cycle with Mem_ready=0.
REQ-040 F=6 with Z=1 -> PC_En=0; F=6 with Z=0 -> PC_En=1.
REQ-041 F=7 -> Halted=1 next cycle, outputs idle for 20 cycles with toggling Mem_ready; Reset -> Halted=0, FETCH, Icount=0000.
REQ-042 Preload to 0xFFFE by running 65534 NOPs (F=8) -> two more instructions give Icount=FFFF then 0000; Reset asserted mid-FETCH wait -> FETCH, Icount=0000.
